// File: rtl/vga_timing_generator.sv
// ----------------------------------------------------------------------------
// vga_timing_generator
//   Generates VGA raster timing (default 640x480@60 Hz) from the system clock.
//   A clock divider issues one pixel_tick every CLK_DIV clocks. The x/y counters
//   advance on that tick. Sync/blank are registered decodes of the next counter
//   value, so they line up with x/y without lag.
//
//   Optional feature macro: VGA_FRAME_COUNT_EN
//     defined   -> frame_count counts completed frames (wraps at 16'hFFFF)
//     undefined -> frame_count tied to 16'd0
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous reset, active-high
//   x, y           out  current raster position
//   active_pixels  out  visible-region qualifier
//   pixel_tick     out  one-clk strobe, counters advance on this cycle
//   line_end       out  strobe on the tick of the last pixel of a line
//   frame_end      out  strobe on the tick of the last pixel of a frame
//   VGA_HS/VGA_VS  out  horizontal / vertical sync (level set by SYNC_POL)
//   VGA_BLANK_N    out  equals active_pixels
//   VGA_SYNC_N     out  constant 0
//   VGA_CLK        out  pixel clock to the DAC (falls with pixel_tick)
//   frame_count    out  completed frames
// ----------------------------------------------------------------------------
module vga_timing_generator #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FRONT  = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BACK   = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FRONT  = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BACK   = 33,
   parameter int unsigned CLK_DIV  = 2,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        active_pixels,
   output logic        pixel_tick,
   output logic        line_end,
   output logic        frame_end,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_BLANK_N,
   output logic        VGA_SYNC_N,
   output logic        VGA_CLK,
   output logic [15:0] frame_count
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

   // 11-bit bounds so an end value of 1024 does not alias to 0
   localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
   localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FRONT);
   localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
   localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FRONT);
   localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FRONT + V_SYNC);

   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       x_q, x_d;
   logic [9:0]       y_q, y_d;
   logic             running_q, running_d;
   logic             active_q, active_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;
   logic             vclk_q, vclk_d;
   logic             tick;
   logic             x_wrap;

   // Divider, counter advance and next-value sync/blank decode
   always_comb begin
      running_d = 1'b1;
      tick      = running_q && (div_q == DIV_LAST);
      x_wrap    = (x_q == H_LAST);
      div_d     = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      x_d       = x_q;
      y_d       = y_q;

      if (tick) begin
         if (x_wrap) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + 10'(1);
         end else begin
            x_d = x_q + 10'(1);
         end
      end

      active_d = running_d && ({1'b0, x_d} < H_ACT_END) && ({1'b0, y_d} < V_ACT_END);
      hs_d     = (({1'b0, x_d} >= HS_START) && ({1'b0, x_d} < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vs_d     = (({1'b0, y_d} >= VS_START) && ({1'b0, y_d} < VS_END)) ? SYNC_POL : ~SYNC_POL;
      // High for the second half of the pixel period; falls as the divider wraps
      vclk_d   = (div_d >= DIV_HALF);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         running_q <= 1'b0;
         active_q  <= 1'b0;
         hs_q      <= ~SYNC_POL;
         vs_q      <= ~SYNC_POL;
         vclk_q    <= 1'b0;
      end else begin
         div_q     <= div_d;
         x_q       <= x_d;
         y_q       <= y_d;
         running_q <= running_d;
         active_q  <= active_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         vclk_q    <= vclk_d;
      end
   end

`ifdef VGA_FRAME_COUNT_EN
   logic [15:0] fc_q, fc_d;

   // Completed-frame counter, wraps naturally at 16 bits
   always_comb begin
      fc_d = fc_q;
      if (frame_end) begin
         fc_d = fc_q + 16'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fc_q <= '0;
      end else begin
         fc_q <= fc_d;
      end
   end

   assign frame_count = fc_q;
`else
   assign frame_count = 16'd0;
`endif

   assign x             = x_q;
   assign y             = y_q;
   assign active_pixels = active_q;
   assign pixel_tick    = tick;
   assign line_end      = tick && x_wrap;
   assign frame_end     = tick && x_wrap && (y_q == V_LAST);
   assign VGA_HS        = hs_q;
   assign VGA_VS        = vs_q;
   assign VGA_BLANK_N   = active_q;
   assign VGA_SYNC_N    = 1'b0;
   assign VGA_CLK       = vclk_q;

endmodule
